// File: rtl/fp32_int2fp_seq.sv
// fp32_int2fp_seq: multi-cycle integer-to-FP32 converter (FCVT.S.W / FCVT.S.WU).
// The operand magnitude is normalised a few bits per cycle, rounded per the
// RISC-V rounding mode, and returned over a valid/ready handshake with NX.
module fp32_int2fp_seq #(
  parameter int SHIFT_STEP = 4  // legal values: 1, 2, 4, 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_unsigned,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_nx
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [5:0]  sc_q, sc_d;
  logic        sign_q, sign_d;
  logic [2:0]  rm_q, rm_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_nx_q, out_nx_d;

  // Rounding datapath: only meaningful while in ROUND, where mag_q[31] is set.
  logic [7:0]  exp_raw;
  logic [7:0]  exp_rnd;
  logic [22:0] frac_trunc;
  logic        guard_bit;
  logic        sticky_bit;
  logic        lsb_bit;
  logic        inc;
  logic [23:0] frac_sum;

  // Round the normalised magnitude to 24 significant bits.
  always_comb begin
    exp_raw    = 8'd158 - {2'b00, sc_q};
    frac_trunc = mag_q[30:8];
    guard_bit  = mag_q[7];
    sticky_bit = |mag_q[6:0];
    lsb_bit    = mag_q[8];
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & (guard_bit | sticky_bit);
      RM_RUP:  inc = ~sign_q & (guard_bit | sticky_bit);
      RM_RMM:  inc = guard_bit;
      default: inc = guard_bit & (sticky_bit | lsb_bit);  // RNE, and 5-7 alias to it
    endcase
    // A carry out of the fraction leaves frac_sum[22:0] at zero, so only the
    // exponent needs bumping.
    frac_sum = {1'b0, frac_trunc} + {23'd0, inc};
    exp_rnd  = exp_raw + {7'd0, frac_sum[23]};
  end

  // Next-state logic for the conversion FSM and its result registers.
  always_comb begin
    // NOTE: every _d starts at its _q value so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    mag_d       = mag_q;
    sc_d        = sc_q;
    sign_d      = sign_q;
    rm_d        = rm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nx_d    = out_nx_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = ~in_unsigned & in_data[31];
          mag_d  = sign_d ? (32'd0 - in_data) : in_data;
          rm_d   = in_rm;
          sc_d   = 6'd0;
          if (mag_d == 32'd0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_data_d  = 32'd0;
            out_nx_d    = 1'b0;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end else if (mag_q[31 -: SHIFT_STEP] == '0) begin
          mag_d = mag_q << SHIFT_STEP;
          sc_d  = sc_q + 6'(SHIFT_STEP);
        end else begin
          mag_d = mag_q << 1;
          sc_d  = sc_q + 6'd1;
        end
      end
      S_ROUND: begin
        out_data_d  = {sign_q, exp_rnd, frac_sum[22:0]};
        out_nx_d    = guard_bit | sticky_bit;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything above; the visible result keeps its old value.
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_nx_d    = out_nx_q;
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of ordering.
    if (rst) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      sc_q        <= '0;
      sign_q      <= 1'b0;
      rm_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nx_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      sc_q        <= sc_d;
      sign_q      <= sign_d;
      rm_q        <= rm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nx_q    <= out_nx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nx    = out_nx_q;

endmodule

// File: tb/tb_fp32_int2fp_seq.sv
// Testbench for fp32_int2fp_seq: directed vector table, randomized operands
// against an arithmetic reference model, and hand-written sequences for
// backpressure, flush and mid-operation reset.
module tb_fp32_int2fp_seq;

  localparam int STEP = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_unsigned;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_nx;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fp32_int2fp_seq #(.SHIFT_STEP(STEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_unsigned (in_unsigned),
    .in_rm       (in_rm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_nx      (out_nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        uns;
    logic [2:0]  rm;
    logic [31:0] exp_data;
    logic        exp_nx;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: exact integer arithmetic on the magnitude, rounding decided by
  // comparing the discarded remainder with one half ulp.
  function automatic void model(input logic [31:0] d, input logic uns, input logic [2:0] rm,
                                output logic [31:0] res, output logic nx, output int lat);
    logic   neg;
    longint m, q, rem, half;
    int     p, e, lz, sh;
    bit     inc;
    neg = !uns && d[31];
    m   = neg ? ((longint'(1) << 32) - longint'(d)) : longint'(d);
    if (m == 0) begin
      res = 32'd0; nx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e   = 127 + p;
    lz  = 31 - p;
    lat = 3 + lz / STEP + lz % STEP;
    if (p <= 23) begin
      q = m << (23 - p); rem = 0; half = 1;
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
    end
    nx = (rem != 0);
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = neg && rem != 0;
      3'd3:    inc = !neg && rem != 0;
      3'd4:    inc = rem >= half && rem != 0;
      default: inc = rem > half || (rem == half && q[0]);
    endcase
    q = q + longint'(inc);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    res = {neg, 8'(e), 23'(q)};
  endfunction

  // Issue one operand from IDLE, wait (bounded) for the result, optionally
  // stall the consumer for `hold` cycles, then complete the handshake.
  task automatic do_conv(input logic [31:0] d, input logic uns, input logic [2:0] rm,
                         input int hold, output logic [31:0] res, output logic nx, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_unsigned = uns; in_rm = rm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = $urandom; in_unsigned = $urandom_range(0, 1); in_rm = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    nx  = out_nx;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d data", h), out_data, res);
      check($sformatf("hold%0d nx", h), 32'(out_nx), 32'(nx));
      check($sformatf("hold%0d valid", h), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d in_ready", h), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t        vecs[12];
  logic [31:0] res, exp_res, d;
  logic        nx, exp_nx, u;
  logic [2:0]  rm;
  int          lat, exp_lat;
  bit          seen;

  initial begin
    vecs[0]  = '{32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0, 13};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0, 13};
    vecs[2]  = '{32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0, 3};
    vecs[3]  = '{32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 1};
    vecs[4]  = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1, 3};
    vecs[5]  = '{32'hFFFF_FFFF, 1'b1, 3'd1, 32'h4F7F_FFFF, 1'b1, 3};
    vecs[6]  = '{32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1, 7};
    vecs[7]  = '{32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1, 7};
    vecs[8]  = '{32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1, 7};
    vecs[9]  = '{32'h0100_0001, 1'b0, 3'd2, 32'h4B80_0000, 1'b1, 7};
    vecs[10] = '{32'h0100_0003, 1'b0, 3'd7, 32'h4B80_0002, 1'b1, 7};
    vecs[11] = '{32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0001, 1'b1, 7};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_unsigned = 1'b0; in_rm = '0; out_ready = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_nx", 32'(out_nx), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      do_conv(vecs[i].data, vecs[i].uns, vecs[i].rm, 0, res, nx, lat);
      check($sformatf("vec%0d data", i), res, vecs[i].exp_data);
      check($sformatf("vec%0d nx", i), 32'(nx), 32'(vecs[i].exp_nx));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Randomized operands with a spread of leading-zero counts.
    for (int i = 0; i < 200; i++) begin
      d  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) d = ~d;
      u  = 1'($urandom_range(0, 1));
      rm = 3'($urandom_range(0, 7));
      model(d, u, rm, exp_res, exp_nx, exp_lat);
      do_conv(d, u, rm, 0, res, nx, lat);
      check($sformatf("rnd%0d data %h u%0d rm%0d", i, d, u, rm), res, exp_res);
      check($sformatf("rnd%0d nx", i), 32'(nx), 32'(exp_nx));
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(exp_lat));
    end

    // Backpressure: result held for 5 stalled cycles, then IDLE after handshake.
    model(32'h0000_0003, 1'b0, 3'd0, exp_res, exp_nx, exp_lat);
    do_conv(32'h0000_0003, 1'b0, 3'd0, 5, res, nx, lat);
    check("bp data", res, exp_res);
    check("bp out_valid after release", 32'(out_valid), 32'd0);
    check("bp in_ready after release", 32'(in_ready), 32'd1);

    // Flush in the middle of normalisation.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001; in_unsigned = 1'b0; in_rm = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush no result", 32'(seen), 32'd0);
    do_conv(32'h0000_0002, 1'b0, 3'd0, 0, res, nx, lat);
    check("post-flush data", res, 32'h4000_0000);
    check("post-flush latency", 32'(lat), 32'd12);

    // Reset in the middle of normalisation.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001; in_unsigned = 1'b0; in_rm = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_conv(32'h0000_0002, 1'b0, 3'd0, 0, res, nx, lat);
    check("post-rst data", res, 32'h4000_0000);

    // Flush beats a simultaneous accept; the old result stays on out_data.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0000; in_unsigned = 1'b0; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush+accept out_valid", 32'(out_valid), 32'd0);
    check("flush+accept in_ready", 32'(in_ready), 32'd1);
    check("flush+accept out_data kept", out_data, 32'h4000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
